// File: rtl/ap_cmd_pkg.sv
// Shared opcode constants, one-hot state encoding and opcode helpers
// for the AP/data command sequencer.
`timescale 1ns/1ps
package ap_cmd_pkg;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_INC        = 3'd1;
  localparam logic [2:0] OP_DEC        = 3'd2;
  localparam logic [2:0] OP_RIGHT      = 3'd3;
  localparam logic [2:0] OP_LEFT       = 3'd4;
  localparam logic [2:0] OP_LOOP_OPEN  = 3'd5;
  localparam logic [2:0] OP_LOOP_CLOSE = 3'd6;
  localparam logic [2:0] OP_RSVD       = 3'd7;

  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_ISSUE = 6'b000010,
    ST_GUARD = 6'b000100,
    ST_WAIT  = 6'b001000,
    ST_EVAL  = 6'b010000,
    ST_DONE  = 6'b100000
  } state_e;

  function automatic logic op_is_move(input logic [2:0] op);
    return (op == OP_INC) || (op == OP_DEC) || (op == OP_RIGHT) || (op == OP_LEFT);
  endfunction

  function automatic logic op_is_loop(input logic [2:0] op);
    return (op == OP_LOOP_OPEN) || (op == OP_LOOP_CLOSE);
  endfunction

  function automatic logic op_is_dec(input logic [2:0] op);
    return (op == OP_DEC) || (op == OP_LEFT);
  endfunction

endpackage

// File: rtl/ap_cmd_sequencer.sv
// Expands run-length Brainfuck commands into single AP/data request pulses
// paced by the line's Ready, and resolves loop brackets from DataZero.
`timescale 1ns/1ps
module ap_cmd_sequencer
  import ap_cmd_pkg::*;
#(
  parameter int COUNT_WIDTH  = 8,
  parameter int GUARD_CYCLES = 1
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   CmdValid,
  input  logic [2:0]             CmdOp,
  input  logic [COUNT_WIDTH-1:0] CmdCount,
  output logic                   CmdReady,
  output logic                   ApRequest,
  output logic                   DataRequest,
  output logic                   Dec,
  input  logic                   ApLineReady,
  input  logic                   DataZero,
  input  logic                   ApZero,
  output logic                   Done,
  output logic                   BranchTaken,
  output logic                   ApWrap
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  // GUARD always lasts at least one cycle; the counter holds cycles left after this one.
  localparam logic [GW-1:0] GUARD_INIT = (GUARD_CYCLES > 1) ? GW'(GUARD_CYCLES - 1) : '0;

  state_e                 state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic [GW-1:0]          guard_q, guard_d;
  logic                   br_res_q, br_res_d;
  logic                   ap_req_q, ap_req_d;
  logic                   data_req_q, data_req_d;
  logic                   dec_q, dec_d;
  logic                   done_q, done_d;
  logic                   branch_q, branch_d;
  logic                   wrap_q, wrap_d;
  logic                   pulse;

  assign CmdReady    = (state_q == ST_IDLE);
  assign pulse       = (state_q == ST_ISSUE) && ApLineReady;
  assign ApRequest   = ap_req_q;
  assign DataRequest = data_req_q;
  assign Dec         = dec_q;
  assign Done        = done_q;
  assign BranchTaken = branch_q;
  assign ApWrap      = wrap_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NOP;
      rem_q      <= '0;
      guard_q    <= '0;
      br_res_q   <= 1'b0;
      ap_req_q   <= 1'b0;
      data_req_q <= 1'b0;
      dec_q      <= 1'b0;
      done_q     <= 1'b0;
      branch_q   <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rem_q      <= rem_d;
      guard_q    <= guard_d;
      br_res_q   <= br_res_d;
      ap_req_q   <= ap_req_d;
      data_req_q <= data_req_d;
      dec_q      <= dec_d;
      done_q     <= done_d;
      branch_q   <= branch_d;
      wrap_q     <= wrap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rem_d    = rem_q;
    guard_d  = guard_q;
    br_res_d = br_res_q;
    case (state_q)
      ST_IDLE: begin
        if (CmdValid) begin
          op_d     = CmdOp;
          rem_d    = CmdCount;
          br_res_d = 1'b0;
          if (op_is_move(CmdOp)) begin
            state_d = (CmdCount == '0) ? ST_DONE : ST_ISSUE;
          end else if (op_is_loop(CmdOp)) begin
            state_d = ST_EVAL;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ISSUE: begin
        if (ApLineReady) begin
          rem_d   = rem_q - 1'b1;
          guard_d = GUARD_INIT;
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (guard_q == '0) state_d = ST_WAIT;
        else               guard_d = guard_q - 1'b1;
      end
      ST_WAIT: begin
        if (ApLineReady) state_d = (rem_q == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_EVAL: begin
        if (ApLineReady) begin
          br_res_d = (op_q == OP_LOOP_OPEN) ? DataZero : ~DataZero;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Dec is only updated at a pulse so it stays stable across the guard/wait gap.
  always_comb begin
    ap_req_d   = 1'b0;
    data_req_d = 1'b0;
    dec_d      = dec_q;
    wrap_d     = wrap_q;
    done_d     = (state_q == ST_DONE);
    branch_d   = (state_q == ST_DONE) && br_res_q;
    if (pulse) begin
      data_req_d = (op_q == OP_INC) || (op_q == OP_DEC);
      ap_req_d   = (op_q == OP_RIGHT) || (op_q == OP_LEFT);
      dec_d      = op_is_dec(op_q);
      if ((op_q == OP_LEFT) && ApZero) wrap_d = 1'b1;
    end
  end

endmodule
